axi4_mem_slave_param: RTL

Parametrised AXI4 slave memory model; the next-generation, configurable replacement for the fixed 32-bit simulation memory slave, driven by the AXI4 master BFM in the axi testbench top.
Adds configurable data/ID width and depth, FIXED/INCR/WRAP bursts, byte strobes, programmable read latency and SLVERR/DECERR error responses.

---
 rtl/axi4_mem_pkg.sv | 52 +++++
 rtl/axi4_burst_addr_gen.sv | 80 ++++++++
 rtl/axi4_mem_slave_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_pkg.sv
// rtl/axi4_mem_pkg.sv - shared types and address-sequencing helpers for the AXI4 memory slave
package axi4_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    // Address of the beat following addr; INCR re-aligns to the beat size,
    // WRAP stays inside the (LEN+1)*2^SIZE aligned window.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] wrap_mask;
        logic [63:0] nxt;
        step      = 64'd1 << size;
        wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_INCR: nxt = (addr & ~(step - 64'd1)) + step;
            BURST_WRAP: nxt = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    nxt = addr;
        endcase
        return nxt;
    endfunction

    // Encodings are ordered by severity, so the numerically larger code wins.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - per-channel burst address, last-beat and error generator
module axi4_burst_addr_gen
    import axi4_mem_pkg::*;
#(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         load,
    input  logic [ID_W-1:0]              ld_id,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [7:0]                   ld_len,
    input  logic [2:0]                   ld_size,
    input  logic [1:0]                   ld_burst,
    input  logic                         advance,
    output logic [ID_W-1:0]              id,
    output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
    output logic                         last,
    output logic [1:0]                   resp
);

    localparam int BYTE_LSB = $clog2(DATA_W / 8);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic              cfg_err_q;
    logic              cfg_err_d;
    logic              out_of_range;

    // Burst-wide protocol errors are decided once, from the address-phase fields.
    always_comb begin
        cfg_err_d = 1'b0;
        if (ld_size > 3'(BYTE_LSB))
            cfg_err_d = 1'b1;
        if (ld_burst == 2'b11)
            cfg_err_d = 1'b1;
        if (ld_burst == BURST_WRAP && !(ld_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            cfg_err_d = 1'b1;
    end

    // Latch the address phase, then step the address once per accepted beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            cfg_err_q <= 1'b0;
        end else if (load) begin
            addr_q    <= ld_addr;
            len_q     <= ld_len;
            cnt_q     <= '0;
            size_q    <= ld_size;
            burst_q   <= ld_burst;
            id_q      <= ld_id;
            cfg_err_q <= cfg_err_d;
        end else if (advance) begin
            addr_q <= ADDR_W'(next_addr(64'(addr_q), size_q, len_q, burst_q));
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    assign out_of_range = (addr_q >> (BYTE_LSB + IDX_W)) != '0;
    assign id           = id_q;
    assign word_idx     = addr_q[BYTE_LSB +: IDX_W];
    assign last         = (cnt_q == len_q);
    assign resp         = cfg_err_q    ? RESP_SLVERR :
                          out_of_range ? RESP_DECERR : RESP_OKAY;

endmodule

// File: rtl/axi4_mem_slave_param.sv
// rtl/axi4_mem_slave_param.sv - parametrised AXI4 slave memory with bursts, strobes and read latency
module axi4_mem_slave_param
    import axi4_mem_pkg::*;
#(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 0,
    parameter int USER_W    = 1
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWLOCK,
    input  logic [3:0]          S_AXI_AWCACHE,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic [3:0]          S_AXI_AWQOS,
    input  logic [3:0]          S_AXI_AWREGION,
    input  logic [USER_W-1:0]   S_AXI_AWUSER,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic [USER_W-1:0]   S_AXI_WUSER,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic [USER_W-1:0]   S_AXI_BUSER,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARLOCK,
    input  logic [3:0]          S_AXI_ARCACHE,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic [3:0]          S_AXI_ARQOS,
    input  logic [3:0]          S_AXI_ARREGION,
    input  logic [USER_W-1:0]   S_AXI_ARUSER,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic [USER_W-1:0]   S_AXI_RUSER,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_e          w_state, w_next;
    r_state_e          r_state, r_next;
    logic              awready_q, wready_q, bvalid_q, arready_q;
    logic [1:0]        wresp_acc, bresp_q, w_acc_next;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ID_W-1:0]   w_id, r_id;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_last, r_last;
    logic [1:0]        w_resp, r_resp;
    logic [3:0]        lat_cnt;
    logic              fetch_done_q, fetch_go, fetch_en, pf_move;
    logic              pf_valid, pf_last, rvalid_q, rlast_q;
    logic [DATA_W-1:0] pf_data, rdata_q;
    logic [1:0]        pf_resp, rresp_q;
    logic              unused_sideband;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign b_hs  = bvalid_q & S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID & arready_q;
    assign r_hs  = rvalid_q & S_AXI_RREADY;

    axi4_burst_addr_gen #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
        .clk(ACLK), .resetn(ARESETN), .load(aw_hs),
        .ld_id(S_AXI_AWID), .ld_addr(S_AXI_AWADDR), .ld_len(S_AXI_AWLEN),
        .ld_size(S_AXI_AWSIZE), .ld_burst(S_AXI_AWBURST), .advance(w_hs),
        .id(w_id), .word_idx(w_idx), .last(w_last), .resp(w_resp)
    );

    axi4_burst_addr_gen #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
        .clk(ACLK), .resetn(ARESETN), .load(ar_hs),
        .ld_id(S_AXI_ARID), .ld_addr(S_AXI_ARADDR), .ld_len(S_AXI_ARLEN),
        .ld_size(S_AXI_ARSIZE), .ld_burst(S_AXI_ARBURST), .advance(fetch_en),
        .id(r_id), .word_idx(r_idx), .last(r_last), .resp(r_resp)
    );

    // Write FSM next state: address, LEN+1 data beats, then hold the response.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write state register; handshake outputs are registered from the next state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
        end
    end

    // A WLAST that disagrees with the beat count marks the burst SLVERR without ending it.
    assign w_acc_next = resp_max(wresp_acc,
                                 resp_max(w_resp, (S_AXI_WLAST != w_last) ? RESP_SLVERR : RESP_OKAY));

    // Accumulate the worst per-beat response and publish it with the last beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wresp_acc <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else if (aw_hs) begin
            wresp_acc <= RESP_OKAY;
        end else if (w_hs) begin
            wresp_acc <= w_acc_next;
            if (w_last)
                bresp_q <= w_acc_next;
        end
    end

    // Byte-lane writes; erroring beats leave the array untouched.
    always_ff @(posedge ACLK) begin
        if (w_hs && w_resp == RESP_OKAY) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // Read FSM next state: latency countdown, then stream until the last handshake.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_WAIT;
            R_WAIT:  if (lat_cnt == 4'd0) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read state register, latency counter and fetch-complete flag.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= R_IDLE;
            arready_q    <= 1'b0;
            lat_cnt      <= 4'd0;
            fetch_done_q <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_hs)
                lat_cnt <= 4'(RD_LAT);
            else if (r_state == R_WAIT && lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;
            if (ar_hs)
                fetch_done_q <= 1'b0;
            else if (fetch_en && r_last)
                fetch_done_q <= 1'b1;
        end
    end

    // The first fetch overlaps the final wait cycle so RVALID lands RD_LAT+2 after AR.
    assign fetch_go = !fetch_done_q &&
                      (r_state == R_DATA || (r_state == R_WAIT && lat_cnt == 4'd0));
    assign pf_move  = pf_valid && (!rvalid_q || S_AXI_RREADY);
    assign fetch_en = fetch_go && (!pf_valid || pf_move);

    // Memory read into the prefetch slot, then into the stable R output register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pf_valid <= 1'b0;
            pf_data  <= '0;
            pf_resp  <= RESP_OKAY;
            pf_last  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            if (fetch_en) begin
                pf_valid <= 1'b1;
                pf_data  <= (r_resp == RESP_OKAY) ? mem[r_idx] : '0;
                pf_resp  <= r_resp;
                pf_last  <= r_last;
            end else if (pf_move) begin
                pf_valid <= 1'b0;
            end
            if (pf_move) begin
                rvalid_q <= 1'b1;
                rdata_q  <= pf_data;
                rresp_q  <= pf_resp;
                rlast_q  <= pf_last;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign unused_sideband = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                               S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER,
                               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                               S_AXI_ARREGION, S_AXI_ARUSER};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = w_id;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BUSER   = '0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RUSER   = '0;

endmodule
